// File: rtl/rom_scan_pkg.sv
// Shared constants and FSM encoding for the ROM scan controller.
// Optional abort input is built when ROM_SCAN_ABORT_EN is defined.
package rom_scan_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int DATA_W_DEF = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int FIFO_CW    = FIFO_PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/rom_scan_fifo.sv
// Small output FIFO for scanned ROM words.
// Clear has priority over write and read.
module rom_scan_fifo
  import rom_scan_pkg::*;
#(
  parameter int W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [W-1:0]       wr_data,
  input  logic               rd_en,
  output logic [W-1:0]       rd_data,
  output logic [FIFO_CW-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [FIFO_PW-1:0] wp;
  logic [FIFO_PW-1:0] rp;
  logic               wr;
  logic               rd;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CW'(FIFO_DEPTH));
  assign wr      = wr_en && !full;
  assign rd      = rd_en && !empty;
  assign rd_data = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wr_data;
        wp      <= wp + FIFO_PW'(1);
      end
      if (rd)
        rp <= rp + FIFO_PW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + FIFO_CW'(1);
        2'b01:   count <= count - FIFO_CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rom_scan_ctrl.sv
// Scans a window of a synchronous ROM into a ready/valid stream.
// Define ROM_SCAN_ABORT_EN to add the abort input.
module rom_scan_ctrl
  import rom_scan_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
`ifdef ROM_SCAN_ABORT_EN
  output logic              done,
  input  logic              abort
`else
  output logic              done
`endif
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_t              state;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W-1:0]   next_addr;
  logic                v1;
  logic                v2;
  logic                l1;
  logic                l2;
  logic [FIFO_CW-1:0]  fcount;
  logic                full;
  logic                empty;
  logic [DATA_W:0]     head;
  logic [3:0]          occ;
  logic                issue;
  logic                last_issue;
  logic                pop;
  logic                flush;
  logic                drain_done;

`ifdef ROM_SCAN_ABORT_EN
  assign flush = abort && (state != S_IDLE);
`else
  assign flush = 1'b0;
`endif

  // Words in the FIFO plus reads still in the ROM pipeline.
  assign occ = 4'(fcount) + {3'b0, v1} + {3'b0, v2};

  assign issue      = (state == S_RUN) && (occ < 4'(FIFO_DEPTH)) && !full;
  assign last_issue = issue && ((cnt + CNT_ONE) == len_q);
  assign pop        = out_valid && out_ready;

  // Finish on the edge that empties the FIFO so done follows the last word.
  assign drain_done = !v1 && !v2 &&
                      (empty || ((fcount == FIFO_CW'(1)) && pop));

  assign out_valid = !empty;
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = head[DATA_W] && !empty;

  rom_scan_fifo #(
    .W (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (flush),
    .wr_en   (v2),
    .wr_data ({l2, rom_data}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fcount),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      next_addr <= '0;
      len_q     <= '0;
      cnt       <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      l1        <= 1'b0;
      l2        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      v1   <= issue && !flush;
      l1   <= last_issue;
      v2   <= v1 && !flush;
      l2   <= l1;
      if (issue && !flush) begin
        rom_addr  <= next_addr;
        next_addr <= next_addr + ADDR_W'(1);
        cnt       <= cnt + CNT_ONE;
      end
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state     <= S_RUN;
              busy      <= 1'b1;
              len_q     <= len;
              cnt       <= '0;
              next_addr <= base_addr;
            end
          end
        end
        S_RUN: begin
          if (last_issue)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_done) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Scoreboard bench for rom_scan_ctrl with a behavioural ROM.
// Abort scenario is included when ROM_SCAN_ABORT_EN is defined.
module tb_rom_scan_ctrl;

  localparam int AW = 3;
  localparam int DW = 4;
  localparam int MAXN = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef ROM_SCAN_ABORT_EN
  logic          abort = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  exp_t exp_q[$];
  logic [DW-1:0] rom_mem [8];
  logic [AW-1:0] addr_log[$];
  int   vtr [MAXN];
  int   ltr [MAXN];
  int   dtr [MAXN];
  int   btr [MAXN];
  int   done_n;
  int   max_out;

  rom_scan_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
`ifdef ROM_SCAN_ABORT_EN
    .done      (done),
    .abort     (abort)
`else
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    rom_mem = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8};
  end

  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", int'(out_data), int'(e.d));
        chk("out_last", int'(out_last), int'(e.l));
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 stall after 2nd word,
  // 3 reset after 3rd word, 4 abort after 2nd word
  task automatic run_scan(input int bb, input int ll,
                          input int mode, input int poke);
    int x0;
    int stall;
    int outst;
    logic [AW-1:0] prev;
    for (int i = 0; i < MAXN; i++) begin
      vtr[i] = 0; ltr[i] = 0; dtr[i] = 0; btr[i] = 0;
    end
    addr_log.delete();
    done_n  = -1;
    max_out = 0;
    stall   = 0;
    @(posedge clk); #1;
    prev      = rom_addr;
    start     = 1'b1;
    base_addr = AW'(bb);
    len       = (AW+1)'(ll);
    for (int i = 0; i < ll; i++)
      exp_q.push_back('{d: DW'(1 << ((bb + i) % 4)), l: (i == ll - 1)});
    x0 = xfers;
    for (int n = 0; n < MAXN; n++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      vtr[n] = int'(out_valid);
      ltr[n] = int'(out_last);
      dtr[n] = int'(done);
      btr[n] = int'(busy);
      if (rom_addr !== prev) begin
        addr_log.push_back(rom_addr);
        prev = rom_addr;
      end
      outst = addr_log.size() - (xfers - x0);
      if (outst > max_out) max_out = outst;
      if (done) begin
        done_n = n;
        break;
      end
      if (n == poke) begin
        start     = 1'b1;
        base_addr = AW'(5);
        len       = (AW+1)'(3);
      end
      if (mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (mode == 2) begin
        if ((xfers - x0) >= 2 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'b1;
        end
      end else if (mode == 3 && (xfers - x0) >= 3) begin
        rst_n = 1'b0;
        #1;
        chk("rst rom_addr", int'(rom_addr), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_last", int'(out_last), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        exp_q.delete();
        rst_n  = 1'b1;
        done_n = n;
        break;
`ifdef ROM_SCAN_ABORT_EN
      end else if (mode == 4 && (xfers - x0) >= 2) begin
        abort     = 1'b1;
        out_ready = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort done", int'(done), 1);
        chk("abort busy", int'(busy), 0);
        out_ready = 1'b1;
        outst = 0;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          outst += int'(out_valid);
        end
        chk("abort valid after", outst, 0);
        done_n = n;
        break;
`endif
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    start     = 1'b0;
    if (done_n < 0) chk("scan timeout", 0, 1);
    @(posedge clk); #1;
    chk("done single pulse", int'(done), 0);
    chk("queue drained", exp_q.size(), 0);
  endtask

  initial begin
    int wexp [4];
    int acc;
    wexp = '{6, 7, 0, 1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rom_addr", int'(rom_addr), 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1'b1;

    // full scan, ready high: latency, throughput, last, done
    run_scan(0, 8, 0, -1);
    chk("full done_n", done_n, 11);
    for (int n = 0; n <= 11; n++) begin
      chk($sformatf("full valid[%0d]", n), vtr[n], int'(n >= 3 && n <= 10));
      chk($sformatf("full last[%0d]", n), ltr[n], int'(n == 10));
      chk($sformatf("full busy[%0d]", n), btr[n], int'(n < 11));
    end

    // wrap-around
    run_scan(6, 4, 0, -1);
    chk("wrap issues", addr_log.size(), 4);
    if (addr_log.size() == 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("wrap addr[%0d]", i), int'(addr_log[i]), wexp[i]);

    // zero length
    run_scan(3, 0, 0, -1);
    chk("len0 done_n", done_n, 0);
    chk("len0 busy", btr[0], 0);
    chk("len0 valid", vtr[0], 0);

    // start while busy is ignored
    run_scan(2, 5, 0, 4);
    chk("busy-start issues", addr_log.size(), 5);

    // reset mid-scan, then a short scan
    run_scan(0, 8, 3, -1);
    run_scan(3, 2, 0, -1);
    chk("post-reset done_n", done_n, 5);

    // backpressure
    run_scan(1, 6, 2, -1);
    chk("bp issues", addr_log.size(), 6);
    chk("bp max outstanding", max_out, 4);

`ifdef ROM_SCAN_ABORT_EN
    run_scan(0, 8, 4, -1);
`endif

    // randomized scans with random backpressure
    for (int r = 0; r < 20; r++) begin
      run_scan(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 1, -1);
      acc = 0;
      for (int n = 0; n <= done_n && n < MAXN; n++)
        acc += int'(vtr[n] == 1 && dtr[n] == 1);
      chk("rand done w/ valid", acc, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
